// File: rtl/adrv9001_tx_ramp_if.sv
// AXI-stream style IQ link used on both sides of the TX ramp stage.
interface adrv9001_tx_ramp_if #(parameter int DW = 32);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/adrv9001_tx_ramp.sv
// TX power ramp/gate ahead of the ADRV9001 s_axis port: linear gain ramp on burst edges, zero-fill on underrun.
// Optional macro ADRV9001_TX_RAMP_TLAST_EN: accepted tlast ends the burst, enable must toggle to rearm.

module adrv9001_tx_ramp_lane #(
  parameter int VEC_W     = 16,
  parameter int RAMP_LOG2 = 6
) (
  input  logic [VEC_W-1:0]   x,
  input  logic [RAMP_LOG2:0] gain,
  output logic [VEC_W-1:0]   y
);
  localparam int PW = VEC_W + RAMP_LOG2 + 2;
  logic signed [PW-1:0] xs, gs, prod;

  // gain is unsigned, so it gets a zero sign bit before the signed multiply
  assign xs   = PW'($signed(x));
  assign gs   = PW'($signed({1'b0, gain}));
  assign prod = xs * gs;
  assign y    = VEC_W'(prod >>> RAMP_LOG2);
endmodule

module adrv9001_tx_ramp #(
  parameter int RAMP_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  adrv9001_tx_ramp_if.slave         s_axis,
  adrv9001_tx_ramp_if.master        m_axis,
  output logic                      busy,
  output logic [1:0]                state,
  output logic [15:0]               underrun_cnt
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 16;
  localparam int GW        = RAMP_LOG2 + 1;
  localparam logic [GW-1:0] UNITY   = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [GW-1:0] LAST_UP = {1'b0, {RAMP_LOG2{1'b1}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } st_t;

  st_t                            st;
  logic [GW-1:0]                  gain;
  logic [31:0]                    m_tdata;
  logic                           m_tvalid;
  logic                           m_tlast;
  logic [15:0]                    urun_q;
  logic                           load;
  logic                           tl_hit;
  logic                           armed;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_in, lane_out;

  // lane 1 = I (upper half), lane 0 = Q
  assign lane_in = s_axis.tdata;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    adrv9001_tx_ramp_lane #(.VEC_W(VEC_W), .RAMP_LOG2(RAMP_LOG2)) u_lane (
      .x    (lane_in[l]),
      .gain (gain),
      .y    (lane_out[l])
    );
  end

  assign load          = (st != IDLE) && (!m_tvalid || m_axis.tready);
  assign s_axis.tready = load;
  assign m_axis.tdata  = m_tdata;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tlast  = m_tlast;
  assign busy          = (st != IDLE);
  assign state         = st;
  assign underrun_cnt  = urun_q;

`ifdef ADRV9001_TX_RAMP_TLAST_EN
  assign tl_hit = load && s_axis.tvalid && s_axis.tlast && (st == RAMP_UP || st == RUN);

  // A burst consumes the arm; it only comes back once enable has been seen low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             armed <= 1'b1;
    else if (st == IDLE && enable && armed) armed <= 1'b0;
    else if (tl_hit)                       armed <= 1'b0;
    else if (!enable)                      armed <= 1'b1;
  end
`else
  assign tl_hit = 1'b0;
  assign armed  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st       <= IDLE;
      gain     <= '0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      urun_q   <= '0;
    end else begin
      if (load) begin
        m_tvalid <= 1'b1;
        m_tdata  <= s_axis.tvalid ? lane_out : '0;
        m_tlast  <= s_axis.tvalid && s_axis.tlast;
        if (!s_axis.tvalid && urun_q != 16'hFFFF) urun_q <= urun_q + 16'd1;
      end else if (m_axis.tready) begin
        m_tvalid <= 1'b0;
      end

      // Active-state transitions only happen on a load, so backpressure freezes the ramp.
      unique case (st)
        IDLE: begin
          if (enable && armed) begin
            st   <= RAMP_UP;
            gain <= '0;
          end
        end
        RAMP_UP: begin
          if (load) begin
            gain <= gain + GW'(1);
            if (!enable || tl_hit)    st <= RAMP_DOWN;
            else if (gain == LAST_UP) st <= RUN;
          end
        end
        RUN: begin
          if (load && (!enable || tl_hit)) st <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (load) begin
            if (gain != '0)          gain <= gain - GW'(1);
            if (enable && armed)     st <= RAMP_UP;
            else if (gain == '0)     st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // UNITY documents the top of the gain range; RUN simply holds gain there.
  logic unused_unity;
  assign unused_unity = ^UNITY;
endmodule
